sema_mbox: RTL

SEMA_MBOX -- requirements
Module: sema_mbox

---
 rtl/sema_pkg.sv | 22 ++
 rtl/sema_chan.sv | 107 ++++++++++
 rtl/sema_mbox.sv | 87 ++++++++
 3 files changed

// File: rtl/sema_pkg.sv
// ---------------------------------------------------------------------------
// sema_pkg
// Shared constants and helpers for the sema_mbox mailbox.
//   SEMA_WIDTH_DEF / SEMA_DEPTH_DEF : default entry width / entries per channel
//   DROP_W / DROP_SAT               : dropped-write counter width and ceiling
//   level_w()                       : bits needed to hold an occupancy 0..DEPTH
// ---------------------------------------------------------------------------
package sema_pkg;

  localparam int SEMA_WIDTH_DEF = 8;
  localparam int SEMA_DEPTH_DEF = 4;

  localparam int                DROP_W   = 8;
  localparam logic [DROP_W-1:0] DROP_SAT = '1;

  // The level must represent DEPTH itself, so it needs one value more than the
  // pointer range.
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sema_chan.sv
// ---------------------------------------------------------------------------
// sema_chan
// One direction of the mailbox: a circular FIFO with write pointer, read
// pointer and level counter. Head data is read combinationally from storage.
// Optional feature: SEMA_DROP_CNT_EN adds a saturating refused-push counter.
//
// Ports
//   clk_s, rst_s : clock, asynchronous active-high reset
//   i_write      : push request (level sensitive, one push per cycle)
//   i_data       : push data
//   i_ready      : reader accepts the head entry
//   o_empty      : level == 0
//   o_full       : level == DEPTH
//   o_level      : occupancy
//   o_data       : head entry (don't-care while o_valid = 0)
//   o_valid      : head entry valid
//   o_drop       : refused-push count, saturating (SEMA_DROP_CNT_EN only)
// ---------------------------------------------------------------------------
module sema_chan
  import sema_pkg::*;
#(
  parameter  int WIDTH = SEMA_WIDTH_DEF,
  parameter  int DEPTH = SEMA_DEPTH_DEF,
  localparam int LVL_W = level_w(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_s,
  input  logic             rst_s,
  input  logic             i_write,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_empty,
  output logic             o_full,
  output logic [LVL_W-1:0] o_level,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
`ifdef SEMA_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0] o_drop
`endif
);

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;

  logic w_pop;
  logic w_push;

  // Pop depends only on registered level, so a push into an empty FIFO cannot
  // be popped in the same cycle. A full FIFO still accepts a push when it pops.
  assign w_pop  = (r_level != '0) && i_ready;
  assign w_push = i_write && ((r_level != LVL_FULL) || w_pop);

  // NOTE: storage has no reset; reset only clears pointers and level, which
  // makes every stored entry unreachable, and lets the array map to plain RAM.
  always_ff @(posedge clk_s) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // DEPTH is a power of two, so pointers wrap from DEPTH-1 to 0 by overflow.
  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef SEMA_DROP_CNT_EN
  logic              w_refused;
  logic [DROP_W-1:0] r_drop;

  assign w_refused = i_write && !w_push;

  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      r_drop <= '0;
    end else if (w_refused && (r_drop != DROP_SAT)) begin
      r_drop <= r_drop + DROP_W'(1);
    end
  end

  assign o_drop = r_drop;
`endif

  // Status comes from registered state only: no path from i_write or i_ready.
  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LVL_FULL);
  assign o_level = r_level;
  assign o_valid = (r_level != '0);
  assign o_data  = r_mem[r_rptr];

endmodule

// File: rtl/sema_mbox.sv
// ---------------------------------------------------------------------------
// sema_mbox
// Two-way mailbox: channel AB carries side A pushes to side B, channel BA
// carries side B pushes to side A. The channels share no state.
// Optional feature: SEMA_DROP_CNT_EN adds sema_drop_i_s_A / sema_drop_i_s_B.
//
// Ports (X = pushing side, Y = other side)
//   clk_s, rst_s          : clock, asynchronous active-high reset
//   sema_write_o_s_X      : side X push request
//   sema_data_o_s_X       : side X push data
//   sema_is_empty_i_s_X   : channel XY empty
//   sema_full_i_s_X       : channel XY full
//   sema_level_i_s_X      : channel XY occupancy
//   sema_data_i_s_Y       : channel XY head entry delivered to side Y
//   sema_valid_i_s_Y      : channel XY head valid
//   sema_ready_o_s_Y      : side Y accepts the channel XY head
//   sema_drop_i_s_X       : channel XY refused-push count (SEMA_DROP_CNT_EN)
// ---------------------------------------------------------------------------
module sema_mbox
  import sema_pkg::*;
#(
  parameter  int WIDTH = SEMA_WIDTH_DEF,
  parameter  int DEPTH = SEMA_DEPTH_DEF,
  localparam int LVL_W = level_w(DEPTH)
) (
  input  logic             clk_s,
  input  logic             rst_s,
  // channel AB
  input  logic             sema_write_o_s_A,
  input  logic [WIDTH-1:0] sema_data_o_s_A,
  output logic             sema_is_empty_i_s_A,
  output logic             sema_full_i_s_A,
  output logic [LVL_W-1:0] sema_level_i_s_A,
  output logic [WIDTH-1:0] sema_data_i_s_B,
  output logic             sema_valid_i_s_B,
  input  logic             sema_ready_o_s_B,
  // channel BA
  input  logic             sema_write_o_s_B,
  input  logic [WIDTH-1:0] sema_data_o_s_B,
  output logic             sema_is_empty_i_s_B,
  output logic             sema_full_i_s_B,
  output logic [LVL_W-1:0] sema_level_i_s_B,
  output logic [WIDTH-1:0] sema_data_i_s_A,
  output logic             sema_valid_i_s_A,
  input  logic             sema_ready_o_s_A
`ifdef SEMA_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0] sema_drop_i_s_A,
  output logic [DROP_W-1:0] sema_drop_i_s_B
`endif
);

  sema_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan_ab (
    .clk_s   (clk_s),
    .rst_s   (rst_s),
    .i_write (sema_write_o_s_A),
    .i_data  (sema_data_o_s_A),
    .i_ready (sema_ready_o_s_B),
    .o_empty (sema_is_empty_i_s_A),
    .o_full  (sema_full_i_s_A),
    .o_level (sema_level_i_s_A),
    .o_data  (sema_data_i_s_B),
    .o_valid (sema_valid_i_s_B)
`ifdef SEMA_DROP_CNT_EN
    ,
    .o_drop  (sema_drop_i_s_A)
`endif
  );

  sema_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan_ba (
    .clk_s   (clk_s),
    .rst_s   (rst_s),
    .i_write (sema_write_o_s_B),
    .i_data  (sema_data_o_s_B),
    .i_ready (sema_ready_o_s_A),
    .o_empty (sema_is_empty_i_s_B),
    .o_full  (sema_full_i_s_B),
    .o_level (sema_level_i_s_B),
    .o_data  (sema_data_i_s_A),
    .o_valid (sema_valid_i_s_A)
`ifdef SEMA_DROP_CNT_EN
    ,
    .o_drop  (sema_drop_i_s_B)
`endif
  );

endmodule
